// File: rtl/counter_pkg.sv
// Shared types and default widths for the two-level down-counting index
// sequencer (counter_down_with_reload) and its reloadable down-counter.
package counter_pkg;

  localparam int DEFAULT_INNER_WIDTH = 4;
  localparam int DEFAULT_OUTER_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : counter_pkg

// File: rtl/down_counter_reload.sv
// Loadable down-counter that saturates at zero. Reset beats load, and load
// beats decrement. A decrement request at zero is ignored, so the count can
// never wrap.
module down_counter_reload #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load has priority, otherwise saturating decrement, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign at_zero_o = (count_q == '0);

endmodule : down_counter_reload

// File: rtl/counter_down_with_reload.sv
// Two-level down-counting index sequencer. A start loads the inner and outer
// maxima. The block then emits (outer, inner) pairs from (outer_max, inner_max)
// down to (0, 0) over valid/ready, and pulses done_o after the final beat.
// Optional macro COUNTER_DOWN_ABORT_EN adds abort_i, which cancels a running
// sequence without a done pulse.
module counter_down_with_reload
  import counter_pkg::*;
#(
  parameter int INNER_WIDTH = DEFAULT_INNER_WIDTH,
  parameter int OUTER_WIDTH = DEFAULT_OUTER_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   counter_rst_i,
  input  logic                   start_i,
  input  logic [INNER_WIDTH-1:0] inner_max_i,
  input  logic [OUTER_WIDTH-1:0] outer_max_i,
  input  logic                   idx_ready_i,
`ifdef COUNTER_DOWN_ABORT_EN
  input  logic                   abort_i,
`endif
  output logic                   idx_valid_o,
  output logic [INNER_WIDTH-1:0] inner_idx_o,
  output logic [OUTER_WIDTH-1:0] outer_idx_o,
  output logic                   inner_last_o,
  output logic                   outer_last_o,
  output logic                   busy_o,
  output logic                   done_o
);

  state_e                 state_q, state_d;
  logic [INNER_WIDTH-1:0] inner_max_q, inner_max_d;

  logic                   abort_s;
  logic                   inner_zero_s, outer_zero_s;
  logic                   inner_load_s, inner_dec_s;
  logic                   outer_load_s, outer_dec_s;
  logic [INNER_WIDTH-1:0] inner_load_val_s;
  logic [OUTER_WIDTH-1:0] outer_load_val_s;

`ifdef COUNTER_DOWN_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  // Sequencer FSM next state. Abort outranks a simultaneous accept.
  // idx_valid_o equals (state == RUN), so an accept is RUN & ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort_s) begin
          state_d = IDLE;
        end else if (idx_ready_i && inner_zero_s && outer_zero_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter control: load on start, clear on abort, and on each accepted beat
  // decrement inner or wrap it (reload) while stepping outer.
  always_comb begin
    inner_load_s     = 1'b0;
    inner_dec_s      = 1'b0;
    inner_load_val_s = inner_max_q;
    outer_load_s     = 1'b0;
    outer_dec_s      = 1'b0;
    outer_load_val_s = '0;
    inner_max_d      = inner_max_q;
    if ((state_q == IDLE) && start_i) begin
      inner_load_s     = 1'b1;
      inner_load_val_s = inner_max_i;
      outer_load_s     = 1'b1;
      outer_load_val_s = outer_max_i;
      inner_max_d      = inner_max_i;
    end else if ((state_q == RUN) && abort_s) begin
      inner_load_s     = 1'b1;
      inner_load_val_s = '0;
      outer_load_s     = 1'b1;
      outer_load_val_s = '0;
    end else if ((state_q == RUN) && idx_ready_i) begin
      if (!inner_zero_s) begin
        inner_dec_s = 1'b1;
      end else if (!outer_zero_s) begin
        inner_load_s     = 1'b1;
        inner_load_val_s = inner_max_q;
        outer_dec_s      = 1'b1;
      end else begin
        inner_dec_s = 1'b0;
      end
    end else begin
      inner_max_d = inner_max_q;
    end
  end

  // FSM state and latched inner reload value.
  always_ff @(posedge clk_i) begin
    if (counter_rst_i) begin
      state_q     <= IDLE;
      inner_max_q <= '0;
    end else begin
      state_q     <= state_d;
      inner_max_q <= inner_max_d;
    end
  end

  down_counter_reload #(.WIDTH(INNER_WIDTH)) u_inner (
    .clk_i        (clk_i),
    .rst_i        (counter_rst_i),
    .load_i       (inner_load_s),
    .load_value_i (inner_load_val_s),
    .dec_i        (inner_dec_s),
    .count_o      (inner_idx_o),
    .at_zero_o    (inner_zero_s)
  );

  down_counter_reload #(.WIDTH(OUTER_WIDTH)) u_outer (
    .clk_i        (clk_i),
    .rst_i        (counter_rst_i),
    .load_i       (outer_load_s),
    .load_value_i (outer_load_val_s),
    .dec_i        (outer_dec_s),
    .count_o      (outer_idx_o),
    .at_zero_o    (outer_zero_s)
  );

  assign idx_valid_o  = (state_q == RUN);
  assign inner_last_o = idx_valid_o && inner_zero_s;
  assign outer_last_o = idx_valid_o && outer_zero_s;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);

endmodule : counter_down_with_reload
